multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle opcode decoder of the 16-bit processor. An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with a variable-latency memory via mem_req/mem_ready. It adds a memory-wait timeout, an illegal-opcode trap and a retired-instruction counter. It sits between the instruction register/memory port and the shared datapath muxes, ALU, register file and PC.

---
 rtl/multicycle_control_unit_pkg.sv | 41 ++++
 rtl/multicycle_control_unit_mem_wait_timer.sv | 29 ++
 rtl/multicycle_control_unit.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes and the
// datapath select codes driven onto the PC and ALU muxes.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam int unsigned OP_LW            = 0;
    localparam int unsigned OP_SW            = 1;
    localparam int unsigned OP_RTYPE_FIRST   = 2;
    localparam int unsigned OP_RTYPE_LAST    = 9;
    localparam int unsigned OP_BEQ           = 10;
    localparam int unsigned OP_BNE           = 11;
    localparam int unsigned OP_J             = 12;
    localparam int unsigned OP_ADDI          = 13;
    localparam int unsigned OP_FIRST_ILLEGAL = 14;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_OP_FUNCT = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_ADDR  = 2'b10;

    function automatic logic is_illegal(input logic [31:0] op);
        return op >= OP_FIRST_ILLEGAL;
    endfunction

    function automatic logic is_rtype(input logic [31:0] op);
        return (op >= OP_RTYPE_FIRST) && (op <= OP_RTYPE_LAST);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags when the limit is reached.
// A MEM_TIMEOUT of 0 disables expiry.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory handshake,
// memory-wait timeout, illegal-opcode trap and retired-instruction counter.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned OPCODE_W     = 4,
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter bit          ILLEGAL_TRAP = 1'b1,
    parameter int unsigned RETIRE_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op,
    output logic                bus_error,
    output logic                retire,
    output logic [RETIRE_W-1:0] retired_cnt,
    output logic [2:0]          state
);

    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q;
    logic [RETIRE_W-1:0]   retired_cnt_q;
    logic                  illegal_q, bus_error_q;
    logic                  latch_op, set_illegal, set_bus_error;
    logic                  timer_clr, timer_en, timer_expired;
    logic [31:0]           op_int, opcode_int;

    assign op_int     = 32'(op_q);
    assign opcode_int = 32'(opcode);

    // Any state change (covers entry to FETCH/MEM) or completed handshake restarts the wait count.
    assign timer_clr = mem_ready || (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clr),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= '0;
            retired_cnt_q <= '0;
            illegal_q     <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_op)      op_q          <= opcode;
            if (retire)        retired_cnt_q <= retired_cnt_q + RETIRE_W'(1);
            if (set_illegal)   illegal_q     <= 1'b1;
            if (set_bus_error) bus_error_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_INC;
        alu_src       = 1'b0;
        alu_op        = ALU_OP_FUNCT;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        latch_op      = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        timer_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timer_expired) begin
                    set_bus_error = 1'b1;
                    state_d       = StTrap;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StDecode: begin
                latch_op = 1'b1;
                if (is_illegal(opcode_int)) begin
                    if (ILLEGAL_TRAP) begin
                        set_illegal = 1'b1;
                        state_d     = StTrap;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (op_int == OP_LW || op_int == OP_SW) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_OP_ADDR;
                    state_d = StMem;
                end else if (op_int == OP_BEQ || op_int == OP_BNE) begin
                    alu_op   = ALU_OP_SUB;
                    pc_src   = PC_SRC_BRANCH;
                    pc_write = (op_int == OP_BEQ) ? zero : !zero;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end else if (op_int == OP_J) begin
                    pc_src   = PC_SRC_JUMP;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end else begin
                    alu_src = (op_int == OP_ADDI);
                    state_d = StWb;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (op_int == OP_SW);
                alu_src = 1'b1;
                alu_op  = ALU_OP_ADDR;
                if (mem_ready) begin
                    if (op_int == OP_SW) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timer_expired) begin
                    set_bus_error = 1'b1;
                    state_d       = StTrap;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_int == OP_LW);
                reg_dst    = is_rtype(op_int);
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign illegal_op  = illegal_q;
    assign bus_error   = bus_error_q;
    assign retired_cnt = retired_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected control vectors are queued with the
// stimulus and compared as the DUT steps through each instruction.
module tb_multicycle_control_unit;

    logic       clk, rst_n, run, zero, mem_ready;
    logic [3:0] opcode;

    logic        mem_req_a, mem_we_a, ir_write_a, pc_write_a, alu_src_a, reg_dst_a;
    logic        mem_to_reg_a, reg_write_a, illegal_op_a, bus_error_a, retire_a;
    logic [1:0]  pc_src_a, alu_op_a;
    logic [15:0] retired_cnt_a;
    logic [2:0]  state_a;

    logic        mem_req_b, mem_we_b, ir_write_b, pc_write_b, alu_src_b, reg_dst_b;
    logic        mem_to_reg_b, reg_write_b, illegal_op_b, bus_error_b, retire_b;
    logic [1:0]  pc_src_b, alu_op_b;
    logic [1:0]  retired_cnt_b;
    logic [2:0]  state_b;

    logic [15:0] act_a, act_b;

    typedef struct {
        logic [3:0]  op;
        logic        mr;
        logic        z;
        logic [15:0] ea;
        logic        cb;
        logic [15:0] eb;
    } ent_t;

    ent_t        sbq[$];
    int          n_chk, n_fail;
    logic [15:0] model_cnt;

    multicycle_control_unit u_dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req_a), .mem_we(mem_we_a), .ir_write(ir_write_a),
        .pc_write(pc_write_a), .pc_src(pc_src_a), .alu_src(alu_src_a), .alu_op(alu_op_a),
        .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a),
        .illegal_op(illegal_op_a), .bus_error(bus_error_a), .retire(retire_a),
        .retired_cnt(retired_cnt_a), .state(state_a)
    );

    multicycle_control_unit #(
        .ILLEGAL_TRAP(1'b0),
        .RETIRE_W    (2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req_b), .mem_we(mem_we_b), .ir_write(ir_write_b),
        .pc_write(pc_write_b), .pc_src(pc_src_b), .alu_src(alu_src_b), .alu_op(alu_op_b),
        .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
        .illegal_op(illegal_op_b), .bus_error(bus_error_b), .retire(retire_b),
        .retired_cnt(retired_cnt_b), .state(state_b)
    );

    assign act_a = {state_a, mem_req_a, mem_we_a, ir_write_a, pc_write_a, pc_src_a, alu_src_a,
                    alu_op_a, reg_dst_a, mem_to_reg_a, reg_write_a, retire_a};
    assign act_b = {state_b, mem_req_b, mem_we_b, ir_write_b, pc_write_b, pc_src_b, alu_src_b,
                    alu_op_b, reg_dst_b, mem_to_reg_b, reg_write_b, retire_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] vec(input logic [2:0] st, input logic mreq, input logic mwe,
                                        input logic irw, input logic pcw, input logic [1:0] pcs,
                                        input logic asrc, input logic [1:0] aop,
                                        input logic rdst, input logic m2r, input logic rw,
                                        input logic ret);
        return {st, mreq, mwe, irw, pcw, pcs, asrc, aop, rdst, m2r, rw, ret};
    endfunction

    task automatic pe(input logic [3:0] op, input logic mr, input logic z, input logic [15:0] ea,
                      input logic cb, input logic [15:0] eb);
        ent_t e;
        e.op = op; e.mr = mr; e.z = z; e.ea = ea; e.cb = cb; e.eb = eb;
        sbq.push_back(e);
    endtask

    // Queue the expected per-cycle outputs of one legal instruction.
    task automatic push_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        logic        sw;
        logic [15:0] e;
        sw = (op == 4'd1);
        for (int i = 0; i < fw; i++)
            pe(op, 1'b0, z, vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0,
                                1'b0, 1'b0), 1'b0, '0);
        pe(op, 1'b1, z, vec(3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                            1'b0), 1'b0, '0);
        pe(op, 1'b1, z, vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                            1'b0), 1'b0, '0);
        case (op)
            4'd0, 4'd1: e = vec(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0,
                                1'b0, 1'b0);
            4'd10: e = vec(3'd3, 1'b0, 1'b0, 1'b0, z, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
            4'd11: e = vec(3'd3, 1'b0, 1'b0, 1'b0, ~z, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
            4'd12: e = vec(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                           1'b1);
            4'd13: e = vec(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0,
                           1'b0);
            default: e = '0 | vec(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0,
                                  1'b0, 1'b0);
        endcase
        pe(op, 1'b1, z, e, 1'b0, '0);
        if (op <= 4'd1) begin
            for (int i = 0; i < mw; i++)
                pe(op, 1'b0, z, vec(3'd4, 1'b1, sw, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0,
                                    1'b0, 1'b0), 1'b0, '0);
            pe(op, 1'b1, z, vec(3'd4, 1'b1, sw, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0,
                                sw), 1'b0, '0);
        end
        if (op == 4'd0)
            pe(op, 1'b1, z, vec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1,
                                1'b1, 1'b1), 1'b0, '0);
        else if ((op >= 4'd2 && op <= 4'd9) || op == 4'd13)
            pe(op, 1'b1, z, vec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, (op != 4'd13),
                                1'b0, 1'b1, 1'b1), 1'b0, '0);
    endtask

    // Pop one entry per cycle; ret_at is the 1-based cycle where the DUT first pulsed retire.
    task automatic drain(output int ret_at);
        ent_t e;
        int   n;
        ret_at = 0;
        n      = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n++;
            opcode = e.op; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            n_chk++;
            if (act_a !== e.ea) begin
                n_fail++;
                $display("FAIL ctrl_a cycle %0d: got %h want %h", n, act_a, e.ea);
            end
            if (e.cb) begin
                n_chk++;
                if (act_b !== e.eb) begin
                    n_fail++;
                    $display("FAIL ctrl_b cycle %0d: got %h want %h", n, act_b, e.eb);
                end
            end
            n_chk++;
            if (retired_cnt_a !== model_cnt) begin
                n_fail++;
                $display("FAIL retired_cnt cycle %0d: got %0d want %0d", n, retired_cnt_a,
                         model_cnt);
            end
            if (e.ea[0]) model_cnt++;
            if (retire_a === 1'b1 && ret_at == 0) ret_at = n;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start();
        int r;
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 4'd0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        run       = 1'b1;
        model_cnt = '0;
        pe(4'd0, 1'b0, 1'b0, '0, 1'b1, '0);
        drain(r);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 4'd2; zero = 1'b0;
        #3;
        chk("reset_ctrl_a", 32'(act_a), 32'd0);
        chk("reset_ctrl_b", 32'(act_b), 32'd0);
        chk("reset_flags", {illegal_op_a, bus_error_a, illegal_op_b, bus_error_b}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold_cnt", 32'(retired_cnt_a), 32'd0);
        chk("reset_hold_state", 32'(state_a), 32'd0);
    endtask

    task automatic test_rtype();
        int r;
        start();
        push_instr(4'd2, 1'b0, 0, 0);
        drain(r);
        chk("rtype_retire_cycle", r, 4);
        chk("rtype_retired_cnt", 32'(retired_cnt_a), 32'd1);
    endtask

    task automatic test_lw_wait();
        int r;
        push_instr(4'd0, 1'b0, 0, 3);
        drain(r);
        chk("lw_wait_cycles", r, 8);
        chk("lw_retired_cnt", 32'(retired_cnt_a), 32'd2);
    endtask

    task automatic test_branch();
        int r;
        push_instr(4'd10, 1'b1, 0, 0);
        drain(r);
        chk("beq_taken_cycles", r, 3);
        push_instr(4'd10, 1'b0, 0, 0);
        drain(r);
        chk("beq_not_taken_cycles", r, 3);
        push_instr(4'd11, 1'b0, 0, 0);
        drain(r);
        chk("bne_taken_cycles", r, 3);
    endtask

    task automatic test_back_to_back();
        int r;
        push_instr(4'd13, 1'b0, 0, 0);
        push_instr(4'd1, 1'b0, 0, 2);
        push_instr(4'd12, 1'b1, 0, 0);
        push_instr(4'd9, 1'b0, 15, 0);
        drain(r);
        chk("b2b_retired_cnt", 32'(retired_cnt_a), 32'd9);
        chk("b2b_no_bus_error", 32'(bus_error_a), 32'd0);
    endtask

    task automatic test_timeout();
        int fetch_cyc;
        bit seen_ret, trapped;
        start();
        mem_ready = 1'b0;
        fetch_cyc = 0; seen_ret = 1'b0; trapped = 1'b0;
        for (int i = 0; i < 40 && !trapped; i++) begin
            @(negedge clk);
            if (state_a == 3'd1) fetch_cyc++;
            if (retire_a === 1'b1) seen_ret = 1'b1;
            if (state_a == 3'd6) trapped = 1'b1;
        end
        chk("timeout_trapped", 32'(trapped), 32'd1);
        chk("timeout_fetch_cycles", fetch_cyc, 16);
        chk("timeout_no_retire", 32'(seen_ret), 32'd0);
        chk("timeout_flags", {bus_error_a, illegal_op_a}, 32'b10);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("trap_ctrl", 32'(act_a), 32'(vec(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00,
                                             1'b0, 1'b0, 1'b0, 1'b0)));
        chk("trap_bus_error_held", 32'(bus_error_a), 32'd1);
        chk("trap_retired_cnt", 32'(retired_cnt_a), 32'd0);
    endtask

    task automatic test_illegal();
        int          r;
        logic [15:0] f_rdy;
        start();
        f_rdy = vec(3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        pe(4'd15, 1'b1, 1'b0, f_rdy, 1'b1, f_rdy);
        pe(4'd15, 1'b0, 1'b0, vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0,
                                  1'b0, 1'b0),
           1'b1, vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        pe(4'd15, 1'b0, 1'b0, vec(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0,
                                  1'b0, 1'b0),
           1'b1, vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        drain(r);
        chk("illegal_trap_flag", 32'(illegal_op_a), 32'd1);
        chk("illegal_trap_no_bus_error", 32'(bus_error_a), 32'd0);
        chk("illegal_nop_flag", 32'(illegal_op_b), 32'd0);
        chk("illegal_nop_retired", 32'(retired_cnt_b), 32'd1);
    endtask

    task automatic test_reset_mid_sw();
        int r;
        start();
        push_instr(4'd4, 1'b0, 0, 0);
        push_instr(4'd1, 1'b0, 0, 3);
        void'(sbq.pop_back());
        void'(sbq.pop_back());
        drain(r);
        chk("mid_sw_in_mem", {state_a, mem_we_a}, {3'd4, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_sw_async_state", 32'(state_a), 32'd0);
        chk("mid_sw_async_mem", {mem_we_a, mem_req_a}, 32'd0);
        chk("mid_sw_async_cnt", 32'(retired_cnt_a), 32'd0);
    endtask

    task automatic test_wrap();
        int r;
        start();
        push_instr(4'd12, 1'b0, 0, 0);
        push_instr(4'd10, 1'b1, 0, 0);
        push_instr(4'd3, 1'b0, 0, 0);
        push_instr(4'd13, 1'b0, 0, 0);
        push_instr(4'd1, 1'b0, 0, 1);
        drain(r);
        chk("wrap_cnt_w16", 32'(retired_cnt_a), 32'd5);
        chk("wrap_cnt_w2", 32'(retired_cnt_b), 32'd1);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; model_cnt = '0;
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 4'd0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_mid_sw();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
